eigen_deflation_sequencer: RTL
==============================

Name: eigen_deflation_sequencer

Overview:
Controller that time-multiplexes a single power-iteration eigen engine across up to SIZE_N successive deflation passes. It replaces the unrolled chain of engines with one shared instance.
- Per pass: launches the engine, waits for its done pulse, writes the eigenvalue to the result store, commands the deflated-matrix reload, then relaunches.
- Stops on the requested pair count, a below-threshold eigenvalue, or a per-pass watchdog timeout.
- Sits between the covariance-matrix stage and the eigenvector/eigenvalue result buffers.

Parameters:
SIZE_N, 8, matrix dimension and maximum number of eigenpairs
DATA_W, 57, signed fixed-point eigenvalue width (16 fractional bits)
MAX_CYCLES, 4096, watchdog limit in cycles per engine pass
IDX_W, $clog2(SIZE_N), pair-index width (derived)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin decomposition; sampled only in IDLE
num_eig  in  IDX_W+1  eigenpairs requested; latched at accepted start
eig_threshold  in  DATA_W  unsigned magnitude floor; latched at accepted start
eng_start  out  1  one-cycle launch pulse to engine
eng_src_sel  out  1  engine matrix source: 0 = input covariance, 1 = deflated buffer
eng_done  in  1  one-cycle engine completion pulse
eng_eigenvalue  in  DATA_W  signed eigenvalue; valid in the eng_done cycle
defl_load  out  1  one-cycle pulse: copy engine deflated output into deflated buffer
res_we  out  1  result write enable
res_idx  out  IDX_W  result slot index
res_value  out  DATA_W  eigenvalue written
busy  out  1  high from LAUNCH through FINISH inclusive
done  out  1  one-cycle completion pulse
eig_count  out  IDX_W+1  pairs written in current/last run
timeout_err  out  1  sticky; cleared by next accepted start or rst

Behaviour:
- States: IDLE, LAUNCH, WAIT, WRITE, DEFLATE, FINISH.
- Outputs are registered or decoded from state only; no combinational input-to-output paths.
- Reset (synchronous, any state including mid-pass): state=IDLE. All outputs 0. Pass counter, eig_count, watchdog, latched num_eig/threshold and captured value all 0. An eng_done arriving after reset is ignored.
- IDLE:
  - start=1 -> latch num_eig (values >SIZE_N clamp to SIZE_N) and eig_threshold; clear pass, eig_count and timeout_err.
  - If the clamped num_eig=0 -> FINISH, else -> LAUNCH.
  - start with busy=1 is ignored.
- LAUNCH (1 cycle): eng_start=1; eng_src_sel=(pass!=0); watchdog cleared -> WAIT. eng_src_sel holds its value through WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - eng_done=1 -> capture eng_eigenvalue -> WRITE.
  - Else watchdog reaching MAX_CYCLES-1 -> timeout_err=1 -> FINISH.
  - eng_done in the same cycle as expiry: done wins, no timeout.
  - eng_done in any state other than WAIT is ignored.
- WRITE (1 cycle):
  - Compute |captured| as a DATA_W unsigned magnitude; the most-negative input saturates to 2^(DATA_W-1)-1.
  - If |captured| < threshold: res_we=0 -> FINISH (early stop, pair not stored).
  - Else: res_we=1, res_idx=pass, res_value=captured; eig_count and pass increment at the clock edge.
  - After a write: if pass+1 == num_eig -> FINISH, else -> DEFLATE.
- DEFLATE (1 cycle): defl_load=1 -> LAUNCH.
- FINISH (1 cycle): done=1, busy=1 -> IDLE. Next cycle busy=0.
- Latency:
  - start sampled at edge T -> eng_start high in cycle T+1.
  - eng_done sampled at edge E -> res_we in cycle E+1; defl_load in E+2; next eng_start in E+3.
  - On the final pass: done in E+2.
- Threshold 0 never triggers early stop.
- Last pass: no defl_load is issued.

Test Plan:
- Normal run: num_eig=3, threshold=0; engine returns 100, 50, 25, each 10 cycles after eng_start -> three res_we at idx 0/1/2 with those values; defl_load exactly twice; eng_src_sel 0, 1, 1; done once; eig_count=3.
- Early stop: num_eig=8, threshold=40; engine returns 100, -60, 30 -> writes idx 0 (100) and idx 1 (-60); third pass produces no write; done; eig_count=2; only 2 defl_load pulses.
- Watchdog: MAX_CYCLES=16, eng_done never asserted -> timeout_err=1 and done exactly 16 cycles after eng_start, no res_we; next start clears timeout_err.
- Boundaries:
  - num_eig=0 -> done 2 cycles after start, no eng_start.
  - num_eig=15 (SIZE_N=8) -> exactly 8 passes.
  - eng_done coincident with watchdog expiry -> write occurs, timeout_err=0.
- Reset mid-WAIT during pass 1 -> all outputs 0 next cycle. A later eng_done produces no write. A fresh start runs from pass 0 with eng_src_sel=0.
- Spurious inputs: start pulsed while busy and eng_done pulsed in IDLE -> no state change, no extra eng_start, no res_we.

Source files
------------

// File: rtl/eigen_deflation_sequencer_if.sv
// Engine handshake and result-store bus shared by the deflation sequencer
// and the eigen engine / result buffers it drives.
interface eigen_deflation_sequencer_if #(
   parameter int DATA_W = 57,
   parameter int IDX_W  = 3
);
   logic              eng_start;
   logic              eng_src_sel;
   logic              eng_done;
   logic [DATA_W-1:0] eng_eigenvalue;
   logic              defl_load;
   logic              res_we;
   logic [IDX_W-1:0]  res_idx;
   logic [DATA_W-1:0] res_value;

   modport master (
      output eng_start, eng_src_sel, defl_load, res_we, res_idx, res_value,
      input  eng_done, eng_eigenvalue
   );

   modport slave (
      input  eng_start, eng_src_sel, defl_load, res_we, res_idx, res_value,
      output eng_done, eng_eigenvalue
   );
endinterface

// File: rtl/eigen_deflation_sequencer.sv
// Time-multiplexes one power-iteration engine over successive deflation passes,
// storing each eigenvalue and stopping on pair count, small eigenvalue or watchdog.
module eigen_deflation_sequencer #(
   parameter int SIZE_N     = 8,
   parameter int DATA_W     = 57,
   parameter int MAX_CYCLES = 4096,
   parameter int IDX_W      = $clog2(SIZE_N)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [IDX_W:0]             num_eig,
   input  logic [DATA_W-1:0]          eig_threshold,
   eigen_deflation_sequencer_if.master bus,
   output logic                       busy,
   output logic                       done,
   output logic [IDX_W:0]             eig_count,
   output logic                       timeout_err
);

   localparam int WD_W = $clog2(MAX_CYCLES) + 1;

   localparam logic [IDX_W:0]      PAIR_MAX = (IDX_W+1)'(SIZE_N);
   localparam logic [IDX_W:0]      PAIR_ONE = (IDX_W+1)'(1);
   localparam logic [IDX_W:0]      PAIR_ZERO = '0;
   localparam logic [WD_W-1:0]     WD_ONE   = WD_W'(1);
   localparam logic [WD_W-1:0]     WD_LIMIT = WD_W'(MAX_CYCLES - 1);
   localparam logic [DATA_W-1:0]   MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0]   MAG_SAT  = {1'b0, {(DATA_W-1){1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_WRITE,
      S_DEFLATE,
      S_FINISH
   } state_t;

   state_t            state;
   state_t            next_state;

   logic [IDX_W:0]    pass_q;
   logic [IDX_W:0]    num_q;
   logic [DATA_W-1:0] thr_q;
   logic [DATA_W-1:0] cap_q;
   logic [WD_W-1:0]   wd_q;

   logic [IDX_W:0]    num_clamped;
   logic [DATA_W-1:0] magnitude;
   logic              below_thr;
   logic              last_pass;
   logic              wd_expire;

   assign num_clamped = (num_eig > PAIR_MAX) ? PAIR_MAX : num_eig;

   // Two's-complement negation of the most-negative code would wrap, so it saturates.
   always_comb begin
      magnitude = cap_q;
      if (cap_q == MOST_NEG) begin
         magnitude = MAG_SAT;
      end else if (cap_q[DATA_W-1]) begin
         magnitude = -cap_q;
      end
   end

   assign below_thr = (magnitude < thr_q);
   assign last_pass = ((pass_q + PAIR_ONE) == num_q);
   assign wd_expire = ((wd_q + WD_ONE) == WD_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               next_state = (num_clamped == PAIR_ZERO) ? S_FINISH : S_LAUNCH;
            end
         end
         S_LAUNCH: next_state = S_WAIT;
         S_WAIT: begin
            if (bus.eng_done) begin
               next_state = S_WRITE;
            end else if (wd_expire) begin
               next_state = S_FINISH;
            end
         end
         S_WRITE: begin
            if (below_thr || last_pass) begin
               next_state = S_FINISH;
            end else begin
               next_state = S_DEFLATE;
            end
         end
         S_DEFLATE: next_state = S_LAUNCH;
         S_FINISH:  next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase
   end

   // Per-run context, captured eigenvalue, watchdog and run status.
   always_ff @(posedge clk) begin
      if (rst) begin
         pass_q      <= '0;
         num_q       <= '0;
         thr_q       <= '0;
         cap_q       <= '0;
         wd_q        <= '0;
         eig_count   <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  num_q       <= num_clamped;
                  thr_q       <= eig_threshold;
                  pass_q      <= '0;
                  eig_count   <= '0;
                  timeout_err <= 1'b0;
               end
            end
            S_LAUNCH: begin
               wd_q <= '0;
            end
            S_WAIT: begin
               wd_q <= wd_q + WD_ONE;
               if (bus.eng_done) begin
                  cap_q <= bus.eng_eigenvalue;
               end else if (wd_expire) begin
                  timeout_err <= 1'b1;
               end
            end
            S_WRITE: begin
               if (!below_thr) begin
                  pass_q    <= pass_q + PAIR_ONE;
                  eig_count <= eig_count + PAIR_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      bus.eng_start   = 1'b0;
      bus.eng_src_sel = 1'b0;
      bus.defl_load   = 1'b0;
      bus.res_we      = 1'b0;
      bus.res_idx     = '0;
      bus.res_value   = '0;
      busy            = 1'b0;
      done            = 1'b0;
      case (state)
         S_LAUNCH: begin
            busy            = 1'b1;
            bus.eng_start   = 1'b1;
            bus.eng_src_sel = (pass_q != PAIR_ZERO);
         end
         S_WAIT: begin
            busy            = 1'b1;
            bus.eng_src_sel = (pass_q != PAIR_ZERO);
         end
         S_WRITE: begin
            busy = 1'b1;
            if (!below_thr) begin
               bus.res_we    = 1'b1;
               bus.res_idx   = pass_q[IDX_W-1:0];
               bus.res_value = cap_q;
            end
         end
         S_DEFLATE: begin
            busy          = 1'b1;
            bus.defl_load = 1'b1;
         end
         S_FINISH: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
